// File: rtl/parity_pkg.sv
// Shared types and line levels for the parity-checked UART transmitter.
package parity_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PSTART    = 3'd1,
    PWAIT_HI  = 3'd2,
    PWAIT_LO  = 3'd3,
    START_BIT = 3'd4,
    DATA      = 3'd5,
    PARITY    = 3'd6,
    STOP      = 3'd7
  } state_t;

  localparam logic TX_IDLE_LVL = 1'b1;
  localparam logic START_LVL   = 1'b0;
  localparam logic STOP_LVL    = 1'b1;
  localparam int   DATA_BITS   = 8;

endpackage

// File: rtl/parity_uart_tx_if.sv
// Byte handshake plus the link to the byte parity unit.
// master = byte source / parity unit side, slave = parity_uart_tx.
interface parity_uart_tx_if;

  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic [7:0] par_data;
  logic       par_start;
  logic       par_busy;
  logic       par_odd;
  logic       par_even;

  modport master (
    output data_in, data_valid, par_busy, par_odd, par_even,
    input  data_ready, par_data, par_start
  );

  modport slave (
    input  data_in, data_valid, par_busy, par_odd, par_even,
    output data_ready, par_data, par_start
  );

endinterface

// File: rtl/parity_tx_baud.sv
// Bit-period counter: o_bit_tick marks the last clk of each serial bit.
module parity_tx_baud #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_bit_tick = !i_clr && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || o_bit_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/parity_uart_tx.sv
// UART transmitter fed through an external byte parity unit.
// Define PARITY_TX_LOCAL_CHECK_EN to cross-check the unit with a local XOR.
module parity_uart_tx
  import parity_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int PAR_TIMEOUT  = 64,
  parameter int ODD_MODE     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  parity_uart_tx_if.slave  bus,
  output logic             tx,
  output logic             frame_done,
  output logic             err
);

  localparam int TMO_W = $clog2(PAR_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(PAR_TIMEOUT);
  localparam logic ODD_BIT = (ODD_MODE != 0);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t           r_state, w_state_next;
  logic [TMO_W-1:0] r_tmo, w_tmo_next;
  logic [2:0]       r_bit_idx, w_bit_idx_next;
  logic [7:0]       r_par_data, w_par_data_next;
  logic             r_par_bit, w_par_bit_next;
  logic             r_tx, w_tx_next;
  logic             w_err, w_frame_done, w_par_start, w_data_ready;
  logic             w_baud_clr, w_bit_tick;
  logic             w_unit_par;

  assign w_unit_par = bus.par_odd ^ ODD_BIT;

`ifdef PARITY_TX_LOCAL_CHECK_EN
  logic w_local_par;
  assign w_local_par = (^r_par_data) ^ ODD_BIT;
`endif

  // Counter only runs while a frame is on the line; it is zero on entry to START_BIT.
  assign w_baud_clr = !((r_state == START_BIT) || (r_state == DATA) ||
                        (r_state == PARITY)    || (r_state == STOP));

  parity_tx_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_baud_clr),
    .o_bit_tick (w_bit_tick)
  );

  always_comb begin
    w_state_next    = r_state;
    w_tmo_next      = r_tmo;
    w_bit_idx_next  = r_bit_idx;
    w_par_data_next = r_par_data;
    w_par_bit_next  = r_par_bit;
    w_err           = 1'b0;
    w_frame_done    = 1'b0;
    w_par_start     = 1'b0;
    w_data_ready    = 1'b0;
    w_tx_next       = TX_IDLE_LVL;

    case (r_state)
      IDLE: begin
        w_data_ready = 1'b1;
        if (bus.data_valid) begin
          w_par_data_next = bus.data_in;
          w_state_next    = PSTART;
        end
      end
      PSTART: begin
        w_par_start  = 1'b1;
        w_tmo_next   = '0;
        w_state_next = PWAIT_HI;
      end
      PWAIT_HI: begin
        if (bus.par_busy) begin
          w_tmo_next   = '0;
          w_state_next = PWAIT_LO;
        end else if (r_tmo == TMO_MAX) begin
          w_err        = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_tmo_next = r_tmo + 1'b1;
        end
      end
      PWAIT_LO: begin
        if (!bus.par_busy) begin
`ifdef PARITY_TX_LOCAL_CHECK_EN
          // Local parity always wins; any disagreement is only flagged.
          w_par_bit_next = w_local_par;
          w_err          = (bus.par_odd == bus.par_even) || (w_local_par != w_unit_par);
          w_state_next   = START_BIT;
`else
          if (bus.par_odd == bus.par_even) begin
            w_err        = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_par_bit_next = w_unit_par;
            w_state_next   = START_BIT;
          end
`endif
        end else if (r_tmo == TMO_MAX) begin
          w_err        = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_tmo_next = r_tmo + 1'b1;
        end
      end
      START_BIT: begin
        if (w_bit_tick) begin
          w_bit_idx_next = '0;
          w_state_next   = DATA;
        end
      end
      DATA: begin
        if (w_bit_tick) begin
          if (r_bit_idx == LAST_BIT) begin
            w_state_next = PARITY;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end
      end
      PARITY: begin
        if (w_bit_tick) begin
          w_state_next = STOP;
        end
      end
      STOP: begin
        if (w_bit_tick) begin
          w_frame_done = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase

    // tx is registered from the next state so it changes exactly at bit boundaries.
    case (w_state_next)
      START_BIT: w_tx_next = START_LVL;
      DATA:      w_tx_next = w_par_data_next[w_bit_idx_next];
      PARITY:    w_tx_next = w_par_bit_next;
      STOP:      w_tx_next = STOP_LVL;
      default:   w_tx_next = TX_IDLE_LVL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_tmo      <= '0;
      r_bit_idx  <= '0;
      r_par_data <= '0;
      r_par_bit  <= 1'b0;
      r_tx       <= TX_IDLE_LVL;
    end else begin
      r_state    <= w_state_next;
      r_tmo      <= w_tmo_next;
      r_bit_idx  <= w_bit_idx_next;
      r_par_data <= w_par_data_next;
      r_par_bit  <= w_par_bit_next;
      r_tx       <= w_tx_next;
    end
  end

  assign tx             = r_tx;
  assign frame_done     = w_frame_done;
  assign err            = w_err;
  assign bus.data_ready = w_data_ready;
  assign bus.par_start  = w_par_start;
  assign bus.par_data   = r_par_data;

endmodule

// File: tb/tb_parity_uart_tx.sv
// Bench for parity_uart_tx: even- and odd-mode instances share one stimulus and parity-unit model.
module tb_parity_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d_in;
  logic       d_valid;
  logic       m_busy, m_odd, m_even;
  int         m_delay = 1;
  int         m_len = 3;
  bit         m_never = 0;
  bit         m_bad = 0;

  parity_uart_tx_if bus0 ();
  parity_uart_tx_if bus1 ();

  assign bus0.data_in = d_in;    assign bus1.data_in = d_in;
  assign bus0.data_valid = d_valid; assign bus1.data_valid = d_valid;
  assign bus0.par_busy = m_busy; assign bus1.par_busy = m_busy;
  assign bus0.par_odd = m_odd;   assign bus1.par_odd = m_odd;
  assign bus0.par_even = m_even; assign bus1.par_even = m_even;

  logic tx0, tx1, fd0, fd1, err0, err1;

  parity_uart_tx #(.CLKS_PER_BIT(4), .PAR_TIMEOUT(64), .ODD_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .tx(tx0), .frame_done(fd0), .err(err0));
  parity_uart_tx #(.CLKS_PER_BIT(4), .PAR_TIMEOUT(64), .ODD_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .tx(tx1), .frame_done(fd1), .err(err1));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] b0;
    logic [10:0] b1;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail = 0;

  // Event counters sampled on the falling edge; tests take deltas.
  int start_cnt = 0, err_cnt = 0, fd_cnt = 0, low_cnt = 0, diverge_cnt = 0;
  always @(negedge clk) begin
    if (bus0.par_start === 1'b1) start_cnt++;
    if (err0 === 1'b1) err_cnt++;
    if (fd0 === 1'b1) fd_cnt++;
    if (tx0 === 1'b0) low_cnt++;
    if (rst_n && ((err0 !== err1) || (fd0 !== fd1) || (bus0.par_start !== bus1.par_start) ||
                  (bus0.data_ready !== bus1.data_ready))) diverge_cnt++;
  end

  // Parity unit model: busy pulse after par_start, answer from popcount of par_data.
  initial begin
    m_busy = 1'b0; m_odd = 1'b0; m_even = 1'b1;
    forever begin
      @(negedge clk);
      if (bus0.par_start === 1'b1 && !m_never) begin
        repeat (m_delay) @(negedge clk);
        m_busy = 1'b1;
        repeat (m_len) @(negedge clk);
        m_busy = 1'b0;
        if (m_bad) begin
          m_odd = 1'b1; m_even = 1'b1;
        end else begin
          m_odd = ^bus0.par_data; m_even = ~(^bus0.par_data);
        end
      end
    end
  end

  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic mode);
    return {1'b1, (^d) ^ mode, d, 1'b0};
  endfunction

  function automatic exp_t make_exp(input logic [7:0] d);
    exp_t e;
    e.data = d; e.b0 = frame_bits(d, 1'b0); e.b1 = frame_bits(d, 1'b1);
    return e;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit hold);
    int n = 0;
    @(negedge clk);
    d_in = b; d_valid = 1'b1;
    while (bus0.data_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    if (!hold) d_valid = 1'b0;
  endtask

  // Waits for a start bit and records one 11-bit frame; ends on the last stop-bit cycle.
  task automatic capture_frame(output bit ok, output logic [10:0] b0, output logic [10:0] b1,
                               output bit stable, output bit fd_ok, output int wait_cyc);
    ok = 0; stable = 1; fd_ok = 1; b0 = '0; b1 = '0; wait_cyc = 0;
    do begin @(negedge clk); wait_cyc++; end while (tx0 !== 1'b0 && wait_cyc < 400);
    if (tx0 !== 1'b0) return;
    ok = 1;
    for (int k = 0; k < 11; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (k != 0 || c != 0) @(negedge clk);
        if (c == 0) begin
          b0[k] = tx0; b1[k] = tx1;
        end else if (tx0 !== b0[k] || tx1 !== b1[k]) begin
          stable = 0;
        end
        if (fd0 !== ((k == 10 && c == 3) ? 1'b1 : 1'b0)) fd_ok = 0;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (tx0 !== 1'b1 || tx1 !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b%b want 11", tx0, tx1); end
    n_checks++; if (bus0.data_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus0.data_ready); end
    n_checks++; if (bus0.par_start !== 1'b0) begin n_fail++; $display("FAIL reset_par_start: got %b want 0", bus0.par_start); end
    n_checks++; if (bus0.par_data !== 8'h00) begin n_fail++; $display("FAIL reset_par_data: got %h want 00", bus0.par_data); end
    n_checks++; if (fd0 !== 1'b0 || err0 !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got fd=%b err=%b want 0 0", fd0, err0); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("reset released");
  endtask

  task automatic test_frame_a5;
    bit ok, st, fdok; logic [10:0] b0, b1; int wc; exp_t e; int eb;
    m_delay = 1; m_len = 3; m_never = 0; m_bad = 0;
    eb = err_cnt;
    send_byte(8'hA5, 0);
    sb.push_back(make_exp(8'hA5));
    capture_frame(ok, b0, b1, st, fdok, wc);
    e = sb.pop_front();
    $display("frame %h: tx0=%b tx1=%b start after %0d cycles", e.data, b0, b1, wc);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL a5_start_bit: got none want start bit"); end
    n_checks++; if (b0 !== e.b0) begin n_fail++; $display("FAIL a5_bits_even: got %b want %b", b0, e.b0); end
    n_checks++; if (b1 !== e.b1) begin n_fail++; $display("FAIL a5_bits_odd: got %b want %b", b1, e.b1); end
    n_checks++; if (!st) begin n_fail++; $display("FAIL a5_bit_width: got unstable bit want 4 cycles each"); end
    n_checks++; if (!fdok) begin n_fail++; $display("FAIL a5_frame_done: got misplaced pulse want cycle 44 only"); end
    n_checks++; if (wc != 6) begin n_fail++; $display("FAIL a5_latency: got %0d want 6", wc); end
    n_checks++; if (err_cnt - eb != 0) begin n_fail++; $display("FAIL a5_err: got %0d pulses want 0", err_cnt - eb); end
  endtask

  task automatic test_odd_07;
    bit ok, st, fdok; logic [10:0] b0, b1; int wc; exp_t e; int sbase;
    m_delay = 0; m_len = 2;
    sbase = start_cnt;
    send_byte(8'h07, 0);
    sb.push_back(make_exp(8'h07));
    capture_frame(ok, b0, b1, st, fdok, wc);
    e = sb.pop_front();
    $display("frame %h: tx0=%b tx1=%b parity %b/%b", e.data, b0, b1, b0[9], b1[9]);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL 07_start_bit: got none want start bit"); end
    n_checks++; if (b0 !== e.b0) begin n_fail++; $display("FAIL 07_bits_even: got %b want %b", b0, e.b0); end
    n_checks++; if (b1 !== e.b1) begin n_fail++; $display("FAIL 07_bits_odd: got %b want %b", b1, e.b1); end
    n_checks++; if (!st || !fdok) begin n_fail++; $display("FAIL 07_timing: got stable=%b fd_ok=%b want 1 1", st, fdok); end
    n_checks++; if (start_cnt - sbase != 1) begin n_fail++; $display("FAIL 07_par_start_width: got %0d cycles want 1", start_cnt - sbase); end
    m_delay = 1; m_len = 3;
  endtask

  task automatic test_timeout;
    int n; int lbase; int ebase;
    m_never = 1;
    lbase = low_cnt; ebase = err_cnt;
    send_byte(8'h3C, 0);
    @(negedge clk);
    n_checks++; if (bus0.par_start !== 1'b1) begin n_fail++; $display("FAIL tmo_par_start: got %b want 1", bus0.par_start); end
    n = 0;
    while (err0 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    $display("timeout: err after %0d cycles from par_start", n);
    n_checks++; if (n != 65) begin n_fail++; $display("FAIL tmo_err_cycle: got %0d want 65", n); end
    @(negedge clk);
    n_checks++; if (err0 !== 1'b0 || err_cnt - ebase != 1) begin n_fail++; $display("FAIL tmo_err_pulse: got err=%b count=%0d want 0 1", err0, err_cnt - ebase); end
    n_checks++; if (bus0.data_ready !== 1'b1) begin n_fail++; $display("FAIL tmo_ready: got %b want 1", bus0.data_ready); end
    n_checks++; if (low_cnt - lbase != 0) begin n_fail++; $display("FAIL tmo_tx_idle: got %0d low cycles want 0", low_cnt - lbase); end
    m_never = 0;
  endtask

  task automatic test_invalid;
    int lbase, ebase, fbase;
`ifdef PARITY_TX_LOCAL_CHECK_EN
    bit ok, st, fdok; logic [10:0] b0, b1; int wc; exp_t e;
`endif
    m_bad = 1;
    lbase = low_cnt; ebase = err_cnt; fbase = fd_cnt;
    send_byte(8'h5A, 0);
`ifdef PARITY_TX_LOCAL_CHECK_EN
    sb.push_back(make_exp(8'h5A));
    capture_frame(ok, b0, b1, st, fdok, wc);
    e = sb.pop_front();
    $display("invalid result, local parity frame %h: tx0=%b tx1=%b", e.data, b0, b1);
    n_checks++; if (!ok || b0 !== e.b0) begin n_fail++; $display("FAIL inv_local_even: got %b want %b", b0, e.b0); end
    n_checks++; if (b1 !== e.b1) begin n_fail++; $display("FAIL inv_local_odd: got %b want %b", b1, e.b1); end
    n_checks++; if (err_cnt - ebase != 1) begin n_fail++; $display("FAIL inv_err: got %0d pulses want 1", err_cnt - ebase); end
`else
    repeat (20) @(negedge clk);
    $display("invalid result for 5a: err pulses %0d", err_cnt - ebase);
    n_checks++; if (err_cnt - ebase != 1) begin n_fail++; $display("FAIL inv_err: got %0d pulses want 1", err_cnt - ebase); end
    n_checks++; if (low_cnt - lbase != 0) begin n_fail++; $display("FAIL inv_no_start: got %0d low cycles want 0", low_cnt - lbase); end
    n_checks++; if (fd_cnt - fbase != 0) begin n_fail++; $display("FAIL inv_no_done: got %0d want 0", fd_cnt - fbase); end
    n_checks++; if (bus0.data_ready !== 1'b1) begin n_fail++; $display("FAIL inv_ready: got %b want 1", bus0.data_ready); end
`endif
    m_bad = 0;
  endtask

  task automatic test_back_to_back;
    bit ok, st, fdok; logic [10:0] b0, b1; int wc; exp_t e; int sbase;
    sbase = start_cnt;
    send_byte(8'h00, 1);
    d_in = 8'hFF;
    sb.push_back(make_exp(8'h00));
    sb.push_back(make_exp(8'hFF));
    capture_frame(ok, b0, b1, st, fdok, wc);
    e = sb.pop_front();
    $display("frame %h: tx0=%b tx1=%b", e.data, b0, b1);
    n_checks++; if (!ok || b0 !== e.b0 || b1 !== e.b1) begin n_fail++; $display("FAIL b2b_first: got %b/%b want %b/%b", b0, b1, e.b0, e.b1); end
    n_checks++; if (bus0.data_ready !== 1'b0 || start_cnt - sbase != 1) begin n_fail++; $display("FAIL b2b_hold: got ready=%b starts=%0d want 0 1", bus0.data_ready, start_cnt - sbase); end
    @(negedge clk);
    n_checks++; if (bus0.data_ready !== 1'b1 || bus0.par_start !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_after_done: got ready=%b start=%b want 1 0", bus0.data_ready, bus0.par_start); end
    @(posedge clk); #1;
    d_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus0.par_start !== 1'b1 || bus0.par_data !== 8'hFF) begin n_fail++; $display("FAIL b2b_second_xfer: got start=%b data=%h want 1 ff", bus0.par_start, bus0.par_data); end
    capture_frame(ok, b0, b1, st, fdok, wc);
    e = sb.pop_front();
    $display("frame %h: tx0=%b tx1=%b", e.data, b0, b1);
    n_checks++; if (!ok || b0 !== e.b0 || b1 !== e.b1) begin n_fail++; $display("FAIL b2b_second: got %b/%b want %b/%b", b0, b1, e.b0, e.b1); end
    n_checks++; if (b0[9] !== 1'b0) begin n_fail++; $display("FAIL b2b_parity_ff: got %b want 0", b0[9]); end
  endtask

  task automatic test_reset_mid_frame;
    int n = 0; int fbase, lbase;
    send_byte(8'h96, 0);
    do begin @(negedge clk); n++; end while (tx0 !== 1'b0 && n < 400);
    repeat (17) @(negedge clk);
    n_checks++; if (tx0 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_bit3: got %b want 0", tx0); end
    #2 rst_n = 1'b0;
    #1;
    $display("reset asserted during data bit 3");
    n_checks++; if (tx0 !== 1'b1 || tx1 !== 1'b1) begin n_fail++; $display("FAIL rst_mid_tx: got %b%b want 11", tx0, tx1); end
    n_checks++; if (bus0.data_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", bus0.data_ready); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    fbase = fd_cnt; lbase = low_cnt;
    repeat (60) @(negedge clk);
    n_checks++; if (fd_cnt - fbase != 0 || low_cnt - lbase != 0) begin n_fail++; $display("FAIL rst_mid_abandon: got done=%0d low=%0d want 0 0", fd_cnt - fbase, low_cnt - lbase); end
    n_checks++; if (bus0.data_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready_after: got %b want 1", bus0.data_ready); end
  endtask

  initial begin
    d_in = 8'h00; d_valid = 1'b0;
    test_reset;
    test_frame_a5;
    test_odd_07;
    test_timeout;
    test_invalid;
    test_back_to_back;
    test_reset_mid_frame;
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_empty: got %0d left want 0", sb.size()); end
    n_checks++; if (diverge_cnt != 0) begin n_fail++; $display("FAIL lane_agreement: got %0d differing cycles want 0", diverge_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
